// File: rtl/rv32_m_requester.sv
// Execute-stage initiator for the external multiply/divide unit: one enable pulse per
// accepted instruction, pipeline stall until ack or watchdog expiry, at most one writeback.
module rv32_m_requester #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_wb_en,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_err,
  output logic            o_m_en,
  output logic [XLEN-1:0] o_m_rs1,
  output logic [XLEN-1:0] o_m_rs2,
  output logic [2:0]      o_m_f3,
  input  logic [XLEN-1:0] i_m_res,
  input  logic            i_m_ack
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic             wb_q;
  logic             expired;

  // cnt counts cycles since the enable pulse, so expiry lands DONE TIMEOUT cycles after o_m_en
  assign expired = (cnt == CNT_LAST);
  assign o_wb_en = wb_q && !i_flush;

  always_comb begin
    o_stall = 1'b0;
    unique case (state)
      IDLE:        o_stall = i_req && !i_flush;
      ISSUE, WAIT: o_stall = 1'b1;
      DRAIN:       o_stall = i_req;
      default:     o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      o_err     <= 1'b0;
      o_m_en    <= 1'b0;
      o_wb_rd   <= '0;
      o_wb_data <= '0;
      o_m_rs1   <= '0;
      o_m_rs2   <= '0;
      o_m_f3    <= '0;
    end else begin
      o_m_en <= 1'b0;
      wb_q   <= 1'b0;
      o_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req && !i_flush) begin
            o_m_rs1 <= i_rs1;
            o_m_rs2 <= i_rs2;
            o_m_f3  <= i_f3;
            rd_q    <= i_rd;
            o_m_en  <= 1'b1;
            cnt     <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_ONE;
          state <= i_flush ? DRAIN : WAIT;
        end
        WAIT: begin
          cnt <= cnt + CNT_ONE;
          if (i_flush) begin
            // a killed instruction never writes back, even if the result arrives now
            state <= (i_m_ack || expired) ? IDLE : DRAIN;
          end else if (i_m_ack) begin
            o_wb_data <= i_m_res;
            o_wb_rd   <= rd_q;
            wb_q      <= 1'b1;
            state     <= DONE;
          end else if (expired) begin
            o_wb_data <= '0;
            o_wb_rd   <= rd_q;
            wb_q      <= 1'b1;
            o_err     <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        DRAIN: begin
          cnt <= cnt + CNT_ONE;
          if (i_m_ack || expired) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_m_requester.sv
// Directed bench for rv32_m_requester: the bench plays both the datapath and the M unit.
module tb_rv32_m_requester;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic            clk, rst, req, flush, m_ack;
  logic [XLEN-1:0] rs1, rs2, m_res;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic            stall, wb_en, err, m_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data, m_rs1, m_rs2;
  logic [2:0]      m_f3;

  int total = 0;
  int bad   = 0;

  rv32_m_requester #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_rs1(rs1), .i_rs2(rs2), .i_f3(f3),
    .i_rd(rd), .i_flush(flush), .o_stall(stall), .o_wb_en(wb_en), .o_wb_rd(wb_rd),
    .o_wb_data(wb_data), .o_err(err), .o_m_en(m_en), .o_m_rs1(m_rs1), .o_m_rs2(m_rs2),
    .o_m_f3(m_f3), .i_m_res(m_res), .i_m_ack(m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".m_en"}, {31'd0, m_en}, 0);
    chk({tag, ".wb_en"}, {31'd0, wb_en}, 0);
    chk({tag, ".err"}, {31'd0, err}, 0);
    chk({tag, ".wb_rd"}, {27'd0, wb_rd}, 0);
    chk({tag, ".wb_data"}, wb_data, 0);
    chk({tag, ".m_rs1"}, m_rs1, 0);
    chk({tag, ".m_rs2"}, m_rs2, 0);
    chk({tag, ".m_f3"}, {29'd0, m_f3}, 0);
  endtask

  // Starts in IDLE; returns during the DONE cycle with req still asserted.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [2:0] f, input logic [4:0] r, input int k,
                    input logic [31:0] res);
    req = 1'b1; rs1 = a; rs2 = b; f3 = f; rd = r;
    #1;
    chk({tag, ".stall_idle"}, {31'd0, stall}, 1);
    chk({tag, ".wb_idle"}, {31'd0, wb_en}, 0);
    tick();
    chk({tag, ".m_en"}, {31'd0, m_en}, 1);
    chk({tag, ".m_rs1"}, m_rs1, a);
    chk({tag, ".m_rs2"}, m_rs2, b);
    chk({tag, ".m_f3"}, {29'd0, m_f3}, {29'd0, f});
    chk({tag, ".stall_issue"}, {31'd0, stall}, 1);
    for (int j = 1; j <= k; j++) begin
      tick();
      chk({tag, ".m_en_off"}, {31'd0, m_en}, 0);
      chk({tag, ".stall_wait"}, {31'd0, stall}, 1);
      chk({tag, ".wb_wait"}, {31'd0, wb_en}, 0);
      if (j == k) begin
        m_ack = 1'b1; m_res = res;
      end
    end
    tick();
    m_ack = 1'b0; m_res = '0;
    #1;
    chk({tag, ".wb_en"}, {31'd0, wb_en}, 1);
    chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, r});
    chk({tag, ".wb_data"}, wb_data, res);
    chk({tag, ".stall_done"}, {31'd0, stall}, 0);
    chk({tag, ".err_done"}, {31'd0, err}, 0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; flush = 1'b0; m_ack = 1'b0;
    rs1 = '0; rs2 = '0; m_res = '0; f3 = '0; rd = '0;

    // reset and idle
    tick(); tick();
    chk_all_zero("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.stall", {31'd0, stall}, 0);
      chk("idle.m_en", {31'd0, m_en}, 0);
      chk("idle.wb_en", {31'd0, wb_en}, 0);
    end
    chk_all_zero("rst_idle");

    // basic MUL 7*6, ack 3 cycles after enable
    op("mul", 7, 6, 3'b000, 5'd5, 3, 42);
    req = 1'b0;
    tick();
    chk("mul.after_wb", {31'd0, wb_en}, 0);
    chk("mul.after_stall", {31'd0, stall}, 0);

    // back-to-back DIV then REM with i_req held through DONE
    op("div", 100, 7, 3'b100, 5'd3, 2, 14);
    rs1 = 100; rs2 = 7; f3 = 3'b110; rd = 5'd4;
    tick();
    chk("b2b.no_dup_wb", {31'd0, wb_en}, 0);
    op("rem", 100, 7, 3'b110, 5'd4, 2, 2);
    req = 1'b0;
    tick();
    chk("rem.after_wb", {31'd0, wb_en}, 0);

    // flush in WAIT, ack arrives in DRAIN, new request waits for it
    req = 1'b1; rs1 = 9; rs2 = 3; f3 = 3'b000; rd = 5'd7;
    tick();
    chk("fl.m_en", {31'd0, m_en}, 1);
    tick();
    flush = 1'b1; req = 1'b0;
    #1;
    chk("fl.stall_wait", {31'd0, stall}, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("fl.stall_drain", {31'd0, stall}, 0);
    req = 1'b1; rs1 = 3; rs2 = 4; f3 = 3'b000; rd = 5'd8;
    #1;
    chk("fl.stall_drain_req", {31'd0, stall}, 1);
    tick();
    chk("fl.no_issue", {31'd0, m_en}, 0);
    chk("fl.wb_drain", {31'd0, wb_en}, 0);
    tick();
    m_ack = 1'b1; m_res = 99;
    chk("fl.no_issue2", {31'd0, m_en}, 0);
    tick();
    m_ack = 1'b0; m_res = '0;
    #1;
    chk("fl.wb_after_ack", {31'd0, wb_en}, 0);
    chk("fl.err_after_ack", {31'd0, err}, 0);
    chk("fl.m_en_idle", {31'd0, m_en}, 0);
    op("post", 3, 4, 3'b000, 5'd8, 1, 12);
    flush = 1'b1;
    #1;
    chk("done.flush_gate", {31'd0, wb_en}, 0);
    flush = 1'b0; req = 1'b0;
    tick();
    chk("post.after_wb", {31'd0, wb_en}, 0);

    // watchdog: no ack, DONE with o_err 8 cycles after enable
    req = 1'b1; rs1 = 5; rs2 = 0; f3 = 3'b101; rd = 5'd9;
    tick();
    chk("to.m_en", {31'd0, m_en}, 1);
    for (int j = 1; j < TO; j++) begin
      tick();
      chk("to.err_early", {31'd0, err}, 0);
      chk("to.wb_early", {31'd0, wb_en}, 0);
      chk("to.stall", {31'd0, stall}, 1);
    end
    tick();
    chk("to.err", {31'd0, err}, 1);
    chk("to.wb_en", {31'd0, wb_en}, 1);
    chk("to.wb_data", wb_data, 0);
    chk("to.wb_rd", {27'd0, wb_rd}, 9);
    req = 1'b0;
    tick();
    chk("to.err_off", {31'd0, err}, 0);
    chk("to.wb_off", {31'd0, wb_en}, 0);
    for (int j = 0; j < 3; j++) tick();
    m_ack = 1'b1; m_res = 77;
    tick();
    m_ack = 1'b0; m_res = '0;
    chk("stray.wb", {31'd0, wb_en}, 0);
    chk("stray.err", {31'd0, err}, 0);
    chk("stray.stall", {31'd0, stall}, 0);
    chk("stray.m_en", {31'd0, m_en}, 0);
    tick();
    chk("stray.wb2", {31'd0, wb_en}, 0);

    // asynchronous reset in the middle of WAIT
    req = 1'b1; rs1 = 11; rs2 = 2; f3 = 3'b100; rd = 5'd6;
    tick();
    chk("ar.m_rs1", m_rs1, 11);
    tick(); tick();
    req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("ar");
    chk("ar.stall", {31'd0, stall}, 0);
    tick();
    rst = 1'b0;
    tick();
    m_ack = 1'b1; m_res = 5;
    tick();
    m_ack = 1'b0; m_res = '0;
    chk("ar.late_wb", {31'd0, wb_en}, 0);
    chk("ar.late_err", {31'd0, err}, 0);
    tick();
    chk("ar.late_wb2", {31'd0, wb_en}, 0);
    chk("ar.stall_end", {31'd0, stall}, 0);
    chk("ar.m_en_end", {31'd0, m_en}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
